// File: rtl/verificador_paquetes_param.sv
// verificador_paquetes_param: parametrised packet-stream checker with header/sequence validation and resync.
// Optional saturating rejected-packet counter (err_cnt) compiled in when CHECKER_ERR_CNT_EN is defined.
module verificador_paquetes_param #(
  parameter int                   BUS_SIZE  = 16,
  parameter int                   WORD_SIZE = 4,
  parameter int                   WORD_NUM  = BUS_SIZE / WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] HEADER    = {WORD_SIZE{1'b1}},
  parameter int                   ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_SIZE-1:0]  data_in,
  input  logic                 valid_in,
  output logic [BUS_SIZE-1:0]  data_out,
  output logic [WORD_NUM-1:0]  ctrl_out,
  output logic                 valid_out,
  output logic                 err,
  output logic                 nxt_err,
  output logic [4:0]           estado,
  output logic [4:0]           estado_proximo
`ifdef CHECKER_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  typedef enum logic [4:0] {
    RESET     = 5'b00001,
    FIRST_PKT = 5'b00010,
    REG_PKT   = 5'b00100,
    F_ERR     = 5'b01000,
    SEQ_ERR   = 5'b10000
  } state_t;

  localparam logic [WORD_SIZE-1:0] SEQ_ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  state_t               estado_r;
  state_t               nxt_s;
  logic [WORD_SIZE-1:0] exp_seq_r;
  logic [WORD_SIZE-1:0] seq_s;
  logic [WORD_SIZE-1:0] hdr_s;
  logic                 hdr_ok_s;
  logic                 accept_s;
  logic                 reject_s;
  logic [WORD_NUM-1:0]  ctrl_s;

  assign hdr_s          = data_in[BUS_SIZE-1 -: WORD_SIZE];
  assign seq_s          = data_in[WORD_SIZE-1:0];
  assign hdr_ok_s       = (hdr_s == HEADER);
  assign estado         = estado_r;
  assign estado_proximo = nxt_s;
  assign nxt_err        = (nxt_s == F_ERR) || (nxt_s == SEQ_ERR);

  // Per-word nonzero flags of the incoming packet
  always_comb begin
    ctrl_s = {WORD_NUM{1'b0}};
    for (int i = 0; i < WORD_NUM; i++) begin
      ctrl_s[i] = |data_in[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Next-state and accept/reject decode; header check takes priority over sequence
  always_comb begin
    nxt_s    = estado_r;
    accept_s = 1'b0;
    reject_s = 1'b0;
    if (!reset) begin
      nxt_s = RESET;
    end else begin
      case (estado_r)
        RESET: begin
          nxt_s = FIRST_PKT;
        end
        FIRST_PKT, F_ERR, SEQ_ERR: begin
          if (valid_in) begin
            if (hdr_ok_s) begin
              nxt_s    = REG_PKT;
              accept_s = 1'b1;
            end else begin
              nxt_s    = F_ERR;
              reject_s = 1'b1;
            end
          end else begin
            nxt_s = estado_r;
          end
        end
        REG_PKT: begin
          if (valid_in) begin
            if (!hdr_ok_s) begin
              nxt_s    = F_ERR;
              reject_s = 1'b1;
            end else if (seq_s != exp_seq_r) begin
              nxt_s    = SEQ_ERR;
              reject_s = 1'b1;
            end else begin
              nxt_s    = REG_PKT;
              accept_s = 1'b1;
            end
          end else begin
            nxt_s = REG_PKT;
          end
        end
        default: begin
          nxt_s = RESET;
        end
      endcase
    end
  end

  // State, expected sequence and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_r  <= RESET;
      exp_seq_r <= {WORD_SIZE{1'b0}};
      data_out  <= {BUS_SIZE{1'b0}};
      ctrl_out  <= {WORD_NUM{1'b0}};
      valid_out <= 1'b0;
      err       <= 1'b0;
    end else begin
      estado_r <= nxt_s;
      err      <= nxt_err;
      if (accept_s) begin
        exp_seq_r <= seq_s + SEQ_ONE;
        data_out  <= data_in;
        ctrl_out  <= ctrl_s;
        valid_out <= 1'b1;
      end else begin
        exp_seq_r <= exp_seq_r;
        data_out  <= {BUS_SIZE{1'b0}};
        ctrl_out  <= {WORD_NUM{1'b0}};
        valid_out <= 1'b0;
      end
    end
  end

`ifdef CHECKER_ERR_CNT_EN
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  // Saturating count of rejected packets
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt <= {ERR_CNT_W{1'b0}};
    end else if (reject_s && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_ONE;
    end else begin
      err_cnt <= err_cnt;
    end
  end
`endif

endmodule

// File: doc/verificador_paquetes_param.md
# verificador_paquetes_param

Parametrised packet-stream checker: the next generation of our fixed 16-bit / 4-word bus FSM, generalised in bus and word width. It adds an input valid qualifier, resynchronisation after errors, and an optional saturating error counter. It sits between the packet source and the downstream consumer. It forwards only accepted packets and flags header and sequence violations.

## Interface
Parameters:
- BUS_SIZE, 16, data bus width in bits; must be an integer multiple of WORD_SIZE.
- WORD_SIZE, 4, word width in bits; also the sequence-counter width.
- WORD_NUM, BUS_SIZE/WORD_SIZE, number of words per packet and the ctrl_out width.
- HEADER, {WORD_SIZE{1'b1}}, required value of the most-significant word.
- ERR_CNT_W, 8, error counter width.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- data_in  in  BUS_SIZE  packet; word i = data_in[i*WORD_SIZE +: WORD_SIZE].
- valid_in  in  1  data_in holds a packet this cycle.
- data_out  out  BUS_SIZE  registered copy of the accepted packet, else 0.
- ctrl_out  out  WORD_NUM  registered; bit i = word i of the accepted packet is nonzero.
- valid_out  out  1  registered; data_out/ctrl_out carry an accepted packet.
- err  out  1  registered; high while state is F_ERR or SEQ_ERR.
- nxt_err  out  1  combinational; estado_proximo is F_ERR or SEQ_ERR.
- estado  out  5  registered state, one-hot.
- estado_proximo  out  5  combinational next state.
- err_cnt  out  ERR_CNT_W  rejected-packet count; only present when the counter is compiled in.

## Operation
- States use one-hot encoding: RESET=5'b00001, FIRST_PKT=5'b00010, REG_PKT=5'b00100, F_ERR=5'b01000, SEQ_ERR=5'b10000.
- A packet is header-ok when its MS word equals HEADER. The seq field is the LS word. The expected-sequence register exp_seq is WORD_SIZE bits wide.
- **RESET:** goes to FIRST_PKT on the first cycle with reset high. No packet is checked in this state.
- **FIRST_PKT:**
  - valid_in with header-ok: accept the packet, go to REG_PKT, set exp_seq = seq+1. Any seq value is accepted.
  - valid_in with a bad header: go to F_ERR.
- **REG_PKT:**
  - valid_in with a bad header: go to F_ERR. The header check has priority over the sequence check.
  - valid_in with header-ok and seq != exp_seq: go to SEQ_ERR.
  - valid_in with header-ok and seq == exp_seq: accept, stay in REG_PKT, exp_seq += 1.
- **F_ERR / SEQ_ERR (resynchronise):**
  - valid_in with header-ok: accept, go to REG_PKT, exp_seq = seq+1.
  - valid_in with a bad header: go to or stay in F_ERR.
- With valid_in low, the state and exp_seq hold.
- exp_seq wraps from 2^WORD_SIZE-1 to 0. A packet whose seq wraps to 0 is legal.
- A rejected packet is any valid_in packet that does not lead to acceptance.

## Timing
- reset low at a clock edge: on the next edge estado=RESET and every registered output is 0. This applies mid-packet and mid-error; exp_seq is also cleared.
- Latency is 1 cycle: a packet accepted at edge N appears on data_out/ctrl_out/valid_out after edge N, for exactly one cycle.
- data_out, ctrl_out and valid_out are 0 in every cycle without an acceptance.
- err rises one cycle after nxt_err rises. It stays high through consecutive errors and falls the cycle after a resynchronising acceptance.
- estado_proximo and nxt_err update combinationally with data_in, valid_in and estado. With reset low, estado_proximo=RESET.
- A valid_in packet presented while estado=RESET is ignored.

## Configuration
- **CHECKER_ERR_CNT_EN defined:**
  - err_cnt is present. It increments by 1 on every rejected packet and saturates at all ones. Reset clears it to 0.
  - Simultaneous reset and rejection: reset wins.
- **Undefined:** the err_cnt port and its counter are absent. All other behaviour is identical.

## Test plan
- **Reset, then in-order stream:** after reset, valid_in=1 with 0xF003, 0xF004, 0xF005.
  - Each packet appears on data_out 1 cycle later.
  - ctrl_out=4'b1001 for each; valid_out=1; err=0; estado=REG_PKT.
- **Sequence wrap:** 0xF00E, 0xF00F, 0xF000 → all accepted, no err.
- **Header error and resync:**
  - In REG_PKT with exp_seq=6, send 0xE006: estado_proximo=F_ERR, nxt_err=1 immediately; err=1 next cycle; data_out=0.
  - Then send 0xF123: accepted (data_out=0xF123), err falls, exp_seq=4.
- **Sequence error:** in REG_PKT with exp_seq=2, send 0xF009 → SEQ_ERR, err=1, valid_out=0. Then 0xF00A → resync, accepted.
- **Gaps and mid-operation reset:**
  - A valid_in=0 cycle between 0xF001 and 0xF002 → state holds, no error.
  - Drive reset=0 while in SEQ_ERR → all outputs 0 and estado=RESET next cycle.
- **With CHECKER_ERR_CNT_EN, ERR_CNT_W=2:** send five bad-header packets → err_cnt counts 1, 2, 3, 3, 3.
